rbin_stream_generator: RTL and testbench

Produces the r-bin stream consumed by the per-theta Legendre histogram accumulator in the LSF segment finder. For one event and one theta bin it takes hit coordinates, computes r = x·cosθ + z·sinθ, and quantises r into a 7-bit bin. It drives `r_bin_V` (TDATA/TVALID/TREADY) and sequences the accumulator's `reset_rbins` / `enable_V` controls: clear, fill, drain, done.

---
 rtl/rbin_stream_generator.sv | 169 ++++++++++++++++
 tb/tb_rbin_stream_generator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbin_stream_generator.sv
// r-bin stream generator: projects hits onto r = x*cos + z*sin, bins r and sequences the
// Legendre accumulator through clear, fill and drain for one event/theta pair.
module rbin_stream_generator #(
    parameter int unsigned R_BINS       = 128,
    parameter int unsigned HIT_W        = 16,
    parameter int unsigned TRIG_W       = 16,
    parameter int unsigned TRIG_FRAC    = 14,
    parameter int unsigned BIN_SHIFT    = 2,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     event_start,
    input  logic signed [TRIG_W-1:0] cos_theta,
    input  logic signed [TRIG_W-1:0] sin_theta,
    input  logic signed [HIT_W:0]    r_min,
    input  logic [2*HIT_W-1:0]       hit_TDATA,
    input  logic                     hit_TVALID,
    output logic                     hit_TREADY,
    input  logic                     hit_TLAST,
    output logic [7:0]               r_bin_V_TDATA,
    output logic                     r_bin_V_TVALID,
    input  logic                     r_bin_V_TREADY,
    output logic                     reset_rbins,
    output logic                     enable_V,
    output logic                     busy,
    output logic                     event_done
);

    localparam int unsigned PROD_W = HIT_W + TRIG_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned REL_W  = SUM_W + 1;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {StIdle, StClear, StFill, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     reset_rbins_d, enable_d, busy_d, done_d;
    logic signed [TRIG_W-1:0] cos_q, sin_q;
    logic signed [HIT_W:0]    r_min_q;

    logic                     stall, accept, last_hs, start_ok;
    logic signed [HIT_W-1:0]  hit_x, hit_z;
    logic signed [PROD_W-1:0] px_d, pz_d, px_q, pz_q;
    logic                     s1_valid_q, s1_last_q, out_last_q;
    logic signed [SUM_W-1:0]  sum, r_val;
    logic signed [REL_W-1:0]  r_rel, bin;
    logic                     in_range;
    logic [7:0]               tdata_d;

    assign stall      = r_bin_V_TVALID & ~r_bin_V_TREADY;
    assign hit_TREADY = (state_q == StFill) & ~stall;
    assign accept     = hit_TVALID & hit_TREADY;
    assign last_hs    = r_bin_V_TVALID & r_bin_V_TREADY & out_last_q;
    assign start_ok   = (state_q == StIdle) & event_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            reset_rbins <= 1'b0;
            enable_V    <= 1'b0;
            busy        <= 1'b0;
            event_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reset_rbins <= reset_rbins_d;
            enable_V    <= enable_d;
            busy        <= busy_d;
            event_done  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (event_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_q == CNT_W'(R_BINS + 1)) begin
                    state_d = StFill;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFill: begin
                if (last_hs) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // enable_V holds through IDLE so the accumulator max stays readable after an event.
    always_comb begin
        reset_rbins_d = (state_d == StClear);
        busy_d        = (state_d != StIdle);
        done_d        = (state_d == StDrain) && (cnt_d == CNT_W'(DRAIN_CYCLES));
        enable_d      = enable_V;
        if (start_ok) begin
            enable_d = 1'b0;
        end
        if (state_d == StFill || state_d == StDrain) begin
            enable_d = 1'b1;
        end
    end

    assign hit_x = hit_TDATA[2*HIT_W-1:HIT_W];
    assign hit_z = hit_TDATA[HIT_W-1:0];
    assign px_d  = PROD_W'(hit_x) * PROD_W'(cos_q);
    assign pz_d  = PROD_W'(hit_z) * PROD_W'(sin_q);

    always_comb begin
        sum      = SUM_W'(px_q) + SUM_W'(pz_q);
        r_val    = sum >>> TRIG_FRAC;
        r_rel    = REL_W'(r_val) - REL_W'(r_min_q);
        bin      = r_rel >>> BIN_SHIFT;
        in_range = ~r_rel[REL_W-1] && ($unsigned(bin) < REL_W'(R_BINS));
        tdata_d  = in_range ? {1'b0, bin[6:0]} : 8'h80;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cos_q          <= '0;
            sin_q          <= '0;
            r_min_q        <= '0;
            px_q           <= '0;
            pz_q           <= '0;
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            out_last_q     <= 1'b0;
            r_bin_V_TVALID <= 1'b0;
            r_bin_V_TDATA  <= '0;
        end else begin
            if (start_ok) begin
                cos_q   <= cos_theta;
                sin_q   <= sin_theta;
                r_min_q <= r_min;
            end
            if (!stall) begin
                px_q           <= px_d;
                pz_q           <= pz_d;
                s1_valid_q     <= accept;
                s1_last_q      <= accept & hit_TLAST;
                r_bin_V_TVALID <= s1_valid_q;
                r_bin_V_TDATA  <= tdata_d;
                out_last_q     <= s1_last_q;
            end
        end
    end

endmodule

// File: tb/tb_rbin_stream_generator.sv
// Self-checking bench for rbin_stream_generator: floor-division reference model, in-order
// beat scoreboard, clear/drain timing and reset-abort checks.
module tb_rbin_stream_generator;

    localparam int R_BINS       = 128;
    localparam int DRAIN_CYCLES = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               event_start = 1'b0;
    logic signed [15:0] cos_theta = '0;
    logic signed [15:0] sin_theta = '0;
    logic signed [16:0] r_min = '0;
    logic [31:0]        hit_TDATA = '0;
    logic               hit_TVALID = 1'b0;
    logic               hit_TLAST = 1'b0;
    logic               r_bin_V_TREADY = 1'b1;
    logic               hit_TREADY;
    logic [7:0]         r_bin_V_TDATA;
    logic               r_bin_V_TVALID;
    logic               reset_rbins, enable_V, busy, event_done;

    rbin_stream_generator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .event_start   (event_start),
        .cos_theta     (cos_theta),
        .sin_theta     (sin_theta),
        .r_min         (r_min),
        .hit_TDATA     (hit_TDATA),
        .hit_TVALID    (hit_TVALID),
        .hit_TREADY    (hit_TREADY),
        .hit_TLAST     (hit_TLAST),
        .r_bin_V_TDATA (r_bin_V_TDATA),
        .r_bin_V_TVALID(r_bin_V_TVALID),
        .r_bin_V_TREADY(r_bin_V_TREADY),
        .reset_rbins   (reset_rbins),
        .enable_V      (enable_V),
        .busy          (busy),
        .event_done    (event_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_hs = -1;
    int    done_cnt = 0;
    int    beats = 0;
    int    m_cos = 0, m_sin = 0, m_rmin = 0;
    bit    prev_stall = 0;
    int    prev_data = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // r is floor(sum / 2^14); the bin is r_rel / 4 once r_rel is known non-negative.
    function automatic int model_bin(input int x, input int z);
        longint sum, r, rel;
        sum = longint'(x) * m_cos + longint'(z) * m_sin;
        r   = sum / 16384;
        if (sum < 0 && (sum % 16384) != 0) r = r - 1;
        rel = r - m_rmin;
        if (rel < 0 || rel / 4 >= R_BINS) return 'h80;
        return int'(rel / 4);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            check(!(reset_rbins && enable_V), "ctrl_exclusive",
                  {30'd0, reset_rbins, enable_V}, 0);
            if (prev_stall)
                check(r_bin_V_TVALID && int'(r_bin_V_TDATA) == prev_data, "stall_hold",
                      int'(r_bin_V_TDATA), prev_data);
            if (r_bin_V_TVALID && !r_bin_V_TREADY)
                check(!hit_TREADY, "stall_hit_tready", int'(hit_TREADY), 0);
            if (r_bin_V_TVALID && r_bin_V_TREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", r_bin_V_TDATA);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check(int'(r_bin_V_TDATA) == e.data, "beat_data", int'(r_bin_V_TDATA),
                          e.data);
                    beats++;
                    if (e.last) last_hs = cyc;
                end
            end
            if (event_done) begin
                check(last_hs >= 0 && cyc == last_hs + DRAIN_CYCLES + 1, "done_timing",
                      cyc - last_hs, DRAIN_CYCLES + 1);
                check(busy, "busy_at_done", int'(busy), 1);
                last_hs = -1;
                done_cnt++;
            end
            prev_stall = r_bin_V_TVALID && !r_bin_V_TREADY;
            prev_data  = int'(r_bin_V_TDATA);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check(!hit_TREADY, {tag, "_hit_tready"}, int'(hit_TREADY), 0);
        check(!r_bin_V_TVALID, {tag, "_tvalid"}, int'(r_bin_V_TVALID), 0);
        check(r_bin_V_TDATA == 8'h00, {tag, "_tdata"}, int'(r_bin_V_TDATA), 0);
        check(!reset_rbins, {tag, "_reset_rbins"}, int'(reset_rbins), 0);
        check(!enable_V, {tag, "_enable_v"}, int'(enable_V), 0);
        check(!busy, {tag, "_busy"}, int'(busy), 0);
        check(!event_done, {tag, "_event_done"}, int'(event_done), 0);
    endtask

    // Returns one cycle after enable_V rises, aligned just after a rising edge.
    task automatic start_event(input int c, input int s, input int rm, input bit inject);
        int n, rcnt, en_cyc;
        bit got;
        @(posedge clk); #1;
        cos_theta   = 16'(c);
        sin_theta   = 16'(s);
        r_min       = 17'(rm);
        event_start = 1'b1;
        m_cos = c; m_sin = s; m_rmin = rm;
        n = cyc;
        @(posedge clk); #1;
        event_start = 1'b0;
        rcnt = 0; got = 0; en_cyc = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (cyc == n + 1) check(busy, "busy_after_start", int'(busy), 1);
            if (reset_rbins) rcnt++;
            if (enable_V) begin
                got = 1;
                en_cyc = cyc;
            end
            if (inject && cyc == n + 5) begin
                event_start = 1'b1;
                cos_theta   = '0;
                r_min       = 17'sd50;
            end else begin
                event_start = 1'b0;
            end
        end
        check(got && en_cyc == n + R_BINS + 3, "enable_rise", en_cyc - n, R_BINS + 3);
        check(rcnt == R_BINS + 2, "clear_len", rcnt, R_BINS + 2);
        @(posedge clk); #1;
    endtask

    // Entered just after a rising edge; leaves just after the edge that took the hit.
    task automatic send_one(input int x, input int z, input bit last, input int pin);
        bit acc;
        beat_t e;
        hit_TDATA  = {16'(x), 16'(z)};
        hit_TVALID = 1'b1;
        hit_TLAST  = last;
        acc = 0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (hit_TREADY) acc = 1;
        end
        check(acc, "hit_accept", int'(acc), 1);
        e.data = model_bin(x, z);
        e.last = last;
        if (pin >= 0) check(e.data == pin, "model_pin", e.data, pin);
        if (acc) exp_q.push_back(e);
        @(posedge clk); #1;
        hit_TVALID = 1'b0;
        hit_TLAST  = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 60 && done_cnt == d0; k++) @(posedge clk);
        check(done_cnt != d0, "done_seen", done_cnt - d0, 1);
        #1;
        @(negedge clk);
        check(!busy, "idle_after_done", int'(busy), 0);
        check(enable_V, "enable_held_idle", int'(enable_V), 1);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen_done;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Event 1: axis-aligned projection, clear sequencing with an ignored restart.
        start_event(16384, 0, 0, 1'b1);
        send_one(100, 5, 1'b0, 'h19);
        @(negedge clk);
        check(!r_bin_V_TVALID, "latency_not_early", int'(r_bin_V_TVALID), 0);
        @(negedge clk);
        check(r_bin_V_TVALID, "latency_valid", int'(r_bin_V_TVALID), 1);
        check(r_bin_V_TDATA == 8'h19, "axis_bin", int'(r_bin_V_TDATA), 'h19);
        @(posedge clk); #1;
        send_one(-4, 0, 1'b0, 'h80);
        send_one(600, 0, 1'b0, 'h80);
        send_one(511, 0, 1'b1, 'h7F);
        wait_done();

        // Event 2: 45 degrees, back-to-back hits with a 3-cycle output stall.
        beats = 0;
        start_event(11585, 11585, 0, 1'b0);
        fork
            begin
                send_one(100, 100, 1'b0, 'h23);
                send_one(20, 20, 1'b0, 'h07);
                send_one(300, 300, 1'b0, 'h6A);
                send_one(0, 0, 1'b0, 'h00);
                send_one(50, 50, 1'b1, 'h11);
            end
            begin
                repeat (3) @(posedge clk);
                #1 r_bin_V_TREADY = 1'b0;
                repeat (3) @(posedge clk);
                #1 r_bin_V_TREADY = 1'b1;
            end
        join
        wait_done();
        check(beats == 5, "beat_count", beats, 5);

        // Event 3: negative r_min, then reset with a stalled beat pending.
        start_event(16384, 0, -100, 1'b0);
        send_one(-50, 0, 1'b0, 'h0C);
        repeat (3) @(posedge clk);
        #1 r_bin_V_TREADY = 1'b0;
        send_one(10, 0, 1'b0, 'h1B);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check(r_bin_V_TVALID, "pending_before_reset", int'(r_bin_V_TVALID), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("abort");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        r_bin_V_TREADY = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (event_done || busy || r_bin_V_TVALID) seen_done = 1;
        end
        check(!seen_done, "no_done_after_abort", int'(seen_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
